// File: rtl/sram_arbiter_if.sv
// Bundle of both requester ports and the SRAM-controller side of the arbiter.
// The slave modport is the arbiter's view: it serves the two requesters and
// drives the SRAM controller. The master modport is the environment's view.
interface sram_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  // Port 0: instruction fetch
  logic                  m0_read_en;
  logic                  m0_write_en;
  logic [ADDR_W-1:0]     m0_addr;
  logic [DATA_W-1:0]     m0_write_data;
  logic [2*DATA_W-1:0]   m0_read_data;
  logic                  m0_ready;
  // Port 1: MEM-stage data cache controller
  logic                  m1_read_en;
  logic                  m1_write_en;
  logic [ADDR_W-1:0]     m1_addr;
  logic [DATA_W-1:0]     m1_write_data;
  logic [2*DATA_W-1:0]   m1_read_data;
  logic                  m1_ready;
  // SRAM controller side
  logic                  sram_read_en;
  logic                  sram_write_en;
  logic [ADDR_W-1:0]     sram_addr;
  logic [DATA_W-1:0]     sram_write_data;
  logic [2*DATA_W-1:0]   sram_read_data;
  logic                  sram_ready;

  modport slave (
    input  m0_read_en, m0_write_en, m0_addr, m0_write_data,
    output m0_read_data, m0_ready,
    input  m1_read_en, m1_write_en, m1_addr, m1_write_data,
    output m1_read_data, m1_ready,
    output sram_read_en, sram_write_en, sram_addr, sram_write_data,
    input  sram_read_data, sram_ready
  );

  modport master (
    output m0_read_en, m0_write_en, m0_addr, m0_write_data,
    input  m0_read_data, m0_ready,
    output m1_read_en, m1_write_en, m1_addr, m1_write_data,
    input  m1_read_data, m1_ready,
    input  sram_read_en, sram_write_en, sram_addr, sram_write_data,
    output sram_read_data, sram_ready
  );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one SRAM controller between instruction fetch
// (port 0) and the data cache controller (port 1). One transaction in flight;
// every output comes straight from a flop. A sticky watchdog flags an SRAM
// controller that stays silent for WDOG_CYC busy cycles.
module sram_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int WDOG_CYC = 1023
) (
  input  logic          clk,
  input  logic          rst,          // asynchronous, active low
  sram_arbiter_if.slave bus,
  output logic          grant,
  output logic          timeout_err
);

  localparam int CNT_W = $clog2(WDOG_CYC + 1);
  localparam logic [CNT_W-1:0] WDOG_MAX = CNT_W'(WDOG_CYC);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]          r_state;
  logic                r_grant;
  logic                r_last_grant;
  logic                r_sram_read_en;
  logic                r_sram_write_en;
  logic [ADDR_W-1:0]   r_sram_addr;
  logic [DATA_W-1:0]   r_sram_write_data;
  logic [2*DATA_W-1:0] r_m0_read_data;
  logic [2*DATA_W-1:0] r_m1_read_data;
  logic                r_m0_ready;
  logic                r_m1_ready;
  logic [CNT_W-1:0]    r_wdog_cnt;
  logic                r_timeout;

  logic                w_req0;
  logic                w_req1;
  logic                w_sel;
  logic                w_sel_write;
  logic                w_sel_read;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_write_data;

  // Arbitration: a lone requester wins; on a tie the port that did not own
  // the previous transaction wins. Write takes priority over read on a port.
  assign w_req0           = bus.m0_read_en | bus.m0_write_en;
  assign w_req1           = bus.m1_read_en | bus.m1_write_en;
  assign w_sel            = (w_req0 & w_req1) ? ~r_last_grant : w_req1;
  assign w_sel_write      = w_sel ? bus.m1_write_en : bus.m0_write_en;
  assign w_sel_read       = (w_sel ? bus.m1_read_en : bus.m0_read_en) & ~w_sel_write;
  assign w_sel_addr       = w_sel ? bus.m1_addr : bus.m0_addr;
  assign w_sel_write_data = w_sel ? bus.m1_write_data : bus.m0_write_data;

  // Transaction FSM: launch from IDLE, wait for sram_ready in BUSY, pulse the
  // owner's ready in RESP.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state           <= S_IDLE;
      r_grant           <= 1'b0;
      r_last_grant      <= 1'b1;
      r_sram_read_en    <= 1'b0;
      r_sram_write_en   <= 1'b0;
      r_sram_addr       <= '0;
      r_sram_write_data <= '0;
      r_m0_read_data    <= '0;
      r_m1_read_data    <= '0;
      r_m0_ready        <= 1'b0;
      r_m1_ready        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req0 | w_req1) begin
            r_grant           <= w_sel;
            r_sram_read_en    <= w_sel_read;
            r_sram_write_en   <= w_sel_write;
            r_sram_addr       <= w_sel_addr;
            r_sram_write_data <= w_sel_write_data;
            r_state           <= S_BUSY;
          end
        end
        S_BUSY: begin
          // Port inputs are deliberately ignored here: a dropped request
          // does not abort the transaction already handed to the SRAM.
          if (bus.sram_ready) begin
            r_sram_read_en  <= 1'b0;
            r_sram_write_en <= 1'b0;
            if (r_grant) begin
              r_m1_read_data <= bus.sram_read_data;
              r_m1_ready     <= 1'b1;
            end else begin
              r_m0_read_data <= bus.sram_read_data;
              r_m0_ready     <= 1'b1;
            end
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_m0_ready   <= 1'b0;
          r_m1_ready   <= 1'b0;
          r_last_grant <= r_grant;
          r_state      <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Watchdog: count silent BUSY cycles, set a sticky flag at WDOG_CYC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wdog_cnt <= '0;
      r_timeout  <= 1'b0;
    end else if (r_state == S_IDLE) begin
      r_wdog_cnt <= '0;
    end else if (r_state == S_BUSY && !bus.sram_ready) begin
      if (r_wdog_cnt != WDOG_MAX) begin
        r_wdog_cnt <= r_wdog_cnt + 1'b1;
      end
      if (r_wdog_cnt == WDOG_MAX - 1'b1) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign bus.sram_read_en    = r_sram_read_en;
  assign bus.sram_write_en   = r_sram_write_en;
  assign bus.sram_addr       = r_sram_addr;
  assign bus.sram_write_data = r_sram_write_data;
  assign bus.m0_read_data    = r_m0_read_data;
  assign bus.m1_read_data    = r_m1_read_data;
  assign bus.m0_ready        = r_m0_ready;
  assign bus.m1_ready        = r_m1_ready;
  assign grant               = r_grant;
  assign timeout_err         = r_timeout;

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter sharing the single 64-bit-read SRAM controller between the instruction-fetch path (port 0) and the MEM-stage data cache controller (port 1). Each port sees the same level-held request / one-cycle-ready handshake the SRAM controller itself presents. Arbitration is round-robin with one transaction in flight. A watchdog flags an SRAM controller that never returns ready.

## Interface
- ADDR_W, 32, address width on both ports and the SRAM side
- DATA_W, 32, write-data width; read data is 2*DATA_W
- WDOG_CYC, 1023, cycles in BUSY without sram_ready before timeout_err sets; counter width $clog2(WDOG_CYC+1)
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- m0_read_en, m1_read_en  in  1  read request, held until the port's ready
- m0_write_en, m1_write_en  in  1  write request, held until the port's ready
- m0_addr, m1_addr  in  ADDR_W  request address
- m0_write_data, m1_write_data  in  DATA_W  store value
- m0_read_data, m1_read_data  out  2*DATA_W  registered read result, valid in the ready cycle
- m0_ready, m1_ready  out  1  one-cycle completion pulse
- sram_read_en, sram_write_en  out  1  to SRAM controller, registered
- sram_addr  out  ADDR_W  registered
- sram_write_data  out  DATA_W  registered
- sram_read_data  in  2*DATA_W  from SRAM controller
- sram_ready  in  1  SRAM controller completion
- grant  out  1  port owning the current/last transaction (0 or 1)
- timeout_err  out  1  sticky watchdog flag

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: req_n = mN_read_en | mN_write_en. None -> stay. One -> grant it. Both -> grant the port not equal to last_grant. Then latch addr, write_data, op into sram_* registers and go to BUSY.
- If a port asserts read_en and write_en together, the transaction is a write; read_en is ignored.
- BUSY: sram_read_en/sram_write_en held at the latched op, other SRAM outputs held constant. Port inputs are not sampled, so a requester dropping its request mid-BUSY does not abort. On sram_ready=1:
  - drop the SRAM enables;
  - capture sram_read_data into the granted port's read_data register, writes included;
  - go to RESP.
- RESP: granted port's mN_ready=1 for exactly one cycle. last_grant <= grant. Next state IDLE.
- The non-granted port's ready is never asserted. Its read_data register holds its previous value.
- Watchdog: counter clears on entering BUSY and increments each BUSY cycle without sram_ready. Reaching WDOG_CYC sets timeout_err, which stays set until reset. The transaction keeps waiting; there is no abort.
- Reset (rst=0, asynchronous):
  - state = IDLE; last_grant = 1, so port 0 wins the first tie;
  - grant = 0; all sram_* outputs = 0; both mN_ready = 0;
  - both read_data = 0; timeout_err = 0; watchdog counter = 0.
  - Mid-transaction reset drops the SRAM enables immediately; the in-flight request is lost, with no ready.

## Timing
- Request visible in IDLE at cycle N -> sram_*_en high from N+1.
- sram_ready at cycle M -> mN_ready and read_data valid at M+1, back in IDLE at M+2.
- Minimum turnaround with sram_ready in the first BUSY cycle: 3 cycles, request-to-ready latency 2.
- Requesters update inputs on the edge ending their ready cycle. The IDLE cycle after RESP therefore samples fresh requests, and a held-then-dropped request is never re-issued.
- Back-to-back contention alternates ports. Each port waits at most one other transaction.
- sram_* outputs and mN_ready/read_data come straight from flops, with no combinational path from port or SRAM inputs.

## Test plan
- Single read: m0_read_en=1, m0_addr=0x100; SRAM model returns 0x11112222_33334444 after 5 cycles -> sram_read_en high for 5 cycles with sram_addr=0x100; m0_ready one pulse with that data; m1_ready never asserts.
- Simultaneous requests right after reset: m0 read 0x0, m1 write 0x200 / 0xDEADBEEF, both held -> port 0 served first, then port 1 with sram_write_data=0xDEADBEEF; grant goes 0 then 1.
- Sustained contention: both ports re-request every cycle for 6 transactions -> grant sequence 0,1,0,1,0,1; each ready pulse exactly one cycle; no gap beyond IDLE/RESP overhead.
- Read+write both asserted on port 1 -> SRAM sees a write only; m1_ready pulses once.
- Watchdog: WDOG_CYC=8, sram_ready held low -> timeout_err rises after 8 BUSY cycles and stays set. A later sram_ready completes the transaction normally, and timeout_err stays 1.
- Reset mid-BUSY: assert rst=0 asynchronously between edges -> sram_read_en falls without waiting for an edge, all outputs at reset values. After release, the next tie grants port 0.
